// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug/loader path: FSM state encodings,
// UART command bytes and the HALT opcode.
package mips_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_PRST  = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5,
        ST_STEP  = 3'd6
    } loader_state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;

    localparam logic [5:0] OPC_HALT = 6'b111111;

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Byte-to-word assembler: shifts received bytes in MSB first and flags the
// cycle in which the final byte of a word arrives.
module word_assembler #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_en,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_DATA-1:0] o_word,
    output logic               o_word_valid
);

    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    logic [NB_DATA-NB_BYTE-1:0] r_shift;
    logic [NB_CNT-1:0]          r_cnt;
    logic                       w_take;

    assign w_take       = i_en & i_rx_valid;
    // The completed word includes the byte arriving this cycle.
    assign o_word       = {r_shift, i_rx_data};
    assign o_word_valid = w_take && (r_cnt == NB_CNT'(N_BYTES - 1));

    always_ff @(posedge clk) begin
        if (!i_rst_n || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_take) begin
            r_shift <= o_word[NB_DATA-NB_BYTE-1:0];
            r_cnt   <= o_word_valid ? '0 : r_cnt + NB_CNT'(1);
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Program loader and run controller for the MIPS pipeline.
// Optional single-step support is enabled with `define LOADER_STEP_EN.
module instr_loader
    import mips_dbg_pkg::*;
#(
    parameter int                 NB_DATA         = 32,
    parameter int                 NB_BYTE         = 8,
    parameter logic [NB_DATA-1:0] ADDR_BASE       = 32'h0000_0000,
    parameter int                 MAX_INSTR       = 64,
    parameter int                 PIPE_RST_CYCLES = 2
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_pipe_halted,
    output logic               o_we_IF,
    output logic [NB_DATA-1:0] o_instruction_data,
    output logic [NB_DATA-1:0] o_inst_addr,
    output logic               o_pipe_rst_n,
    output logic               o_halt,
    output logic [2:0]         o_state,
    output logic               o_loaded,
    output logic               o_error
);

    localparam int NB_WCNT = $clog2(MAX_INSTR + 1);

    loader_state_t      r_state;
    logic               r_we;
    logic [NB_DATA-1:0] r_data;
    logic [NB_DATA-1:0] r_addr;
    logic               r_pipe_rst_n;
    logic               r_halt;
    logic               r_loaded;
    logic               r_error;
    logic [NB_WCNT-1:0] r_word_cnt;
    logic [3:0]         r_prst_cnt;
`ifdef LOADER_STEP_EN
    logic               r_step_pend;
`endif

    logic               w_cmd_state;
    logic               w_clear;
    logic               w_asm_en;
    logic [NB_DATA-1:0] w_word;
    logic               w_word_valid;

    assign w_cmd_state = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_clear     = w_cmd_state && i_rx_valid && (i_rx_data == CMD_LOAD);
    // A byte arriving during WRITE already belongs to the next word.
    assign w_asm_en    = (r_state == ST_LOAD) || (r_state == ST_WRITE);

    word_assembler #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_word_assembler (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_clear),
        .i_en         (w_asm_en),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_data       <= '0;
            r_addr       <= ADDR_BASE;
            r_pipe_rst_n <= 1'b0;
            r_halt       <= 1'b1;
            r_loaded     <= 1'b0;
            r_error      <= 1'b0;
            r_word_cnt   <= '0;
            r_prst_cnt   <= '0;
`ifdef LOADER_STEP_EN
            r_step_pend  <= 1'b0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == CMD_LOAD) begin
                            r_state      <= ST_LOAD;
                            r_loaded     <= 1'b0;
                            r_error      <= 1'b0;
                            r_addr       <= ADDR_BASE;
                            r_word_cnt   <= '0;
                            r_pipe_rst_n <= 1'b0;
                            r_halt       <= 1'b1;
                        end else if (i_rx_data == CMD_RUN && r_loaded) begin
                            r_state      <= ST_PRST;
                            r_pipe_rst_n <= 1'b0;
                            r_halt       <= 1'b1;
                            r_prst_cnt   <= 4'(PIPE_RST_CYCLES - 1);
                        end
`ifdef LOADER_STEP_EN
                        else if (i_rx_data == CMD_STEP && r_loaded) begin
                            if (r_state == ST_DONE) begin
                                r_state      <= ST_STEP;
                                r_halt       <= 1'b0;
                                r_pipe_rst_n <= 1'b1;
                            end else begin
                                // First step from IDLE resets the pipeline first.
                                r_state      <= ST_PRST;
                                r_pipe_rst_n <= 1'b0;
                                r_halt       <= 1'b1;
                                r_prst_cnt   <= 4'(PIPE_RST_CYCLES - 1);
                                r_step_pend  <= 1'b1;
                            end
                        end
`endif
                    end
                end

                ST_LOAD: begin
                    r_pipe_rst_n <= 1'b0;
                    if (w_word_valid) begin
                        r_state <= ST_WRITE;
                        r_we    <= 1'b1;
                        r_data  <= w_word;
                    end
                end

                ST_WRITE: begin
                    r_addr     <= r_addr + NB_DATA'(4);
                    r_word_cnt <= r_word_cnt + NB_WCNT'(1);
                    if (r_data[NB_DATA-1 -: 6] == OPC_HALT) begin
                        r_loaded <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else if (r_word_cnt == NB_WCNT'(MAX_INSTR - 1)) begin
                        r_error <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end

                ST_PRST: begin
                    if (r_prst_cnt == 4'd0) begin
                        r_pipe_rst_n <= 1'b1;
                        r_halt       <= 1'b0;
                        r_state      <= ST_RUN;
`ifdef LOADER_STEP_EN
                        if (r_step_pend) begin
                            r_state     <= ST_STEP;
                            r_step_pend <= 1'b0;
                        end
`endif
                    end else begin
                        r_prst_cnt <= r_prst_cnt - 4'd1;
                    end
                end

                ST_RUN: begin
                    if (i_pipe_halted) begin
                        r_state <= ST_DONE;
                        r_halt  <= 1'b1;
                    end
                end

`ifdef LOADER_STEP_EN
                ST_STEP: begin
                    r_state <= ST_DONE;
                    r_halt  <= 1'b1;
                end
`endif

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_we_IF            = r_we;
    assign o_instruction_data = r_data;
    assign o_inst_addr        = r_addr;
    assign o_pipe_rst_n       = r_pipe_rst_n;
    assign o_halt             = r_halt;
    assign o_state            = r_state;
    assign o_loaded           = r_loaded;
    assign o_error            = r_error;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: program table, directed run/reset/step
// sequences and randomized loads checked against a write-list reference model.
module tb_instr_loader;

    localparam int MAXI = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        pipe_halted;
    logic        we;
    logic [31:0] idata;
    logic [31:0] iaddr;
    logic        pipe_rst_n;
    logic        halt;
    logic [2:0]  state;
    logic        loaded;
    logic        error;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [63:0] q_wr[$];   // observed {addr, data}
    logic [31:0] q_exp[$];  // expected data, addresses implied by position
    logic [31:0] prog[$];

    always #5 clk = ~clk;

    instr_loader #(
        .MAX_INSTR       (MAXI),
        .PIPE_RST_CYCLES (2)
    ) dut (
        .clk                (clk),
        .i_rst_n            (rst_n),
        .i_rx_data          (rx_data),
        .i_rx_valid         (rx_valid),
        .i_pipe_halted      (pipe_halted),
        .o_we_IF            (we),
        .o_instruction_data (idata),
        .o_inst_addr        (iaddr),
        .o_pipe_rst_n       (pipe_rst_n),
        .o_halt             (halt),
        .o_state            (state),
        .o_loaded           (loaded),
        .o_error            (error)
    );

    always @(negedge clk) if (we) q_wr.push_back({iaddr, idata});

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned gap_max);
        for (int unsigned i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8]);
            idle($urandom_range(gap_max, 0));
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".state"},  32'(state), 32'd0);
        check({tag, ".we"},     32'(we), 32'd0);
        check({tag, ".data"},   idata, 32'h0);
        check({tag, ".addr"},   iaddr, 32'h0);
        check({tag, ".rst_n"},  32'(pipe_rst_n), 32'd0);
        check({tag, ".halt"},   32'(halt), 32'd1);
        check({tag, ".loaded"}, 32'(loaded), 32'd0);
        check({tag, ".error"},  32'(error), 32'd0);
    endtask

    // Reference: words are written in order at ADDR_BASE+4*i until a HALT
    // opcode is written or MAXI words have been written.
    task automatic model_load(output bit exp_loaded, output bit exp_error);
        exp_loaded = 1'b0;
        exp_error  = 1'b0;
        q_exp.delete();
        foreach (prog[i]) begin
            q_exp.push_back(prog[i]);
            if (prog[i][31:26] == 6'h3F) begin exp_loaded = 1'b1; break; end
            if (q_exp.size() == MAXI)     begin exp_error  = 1'b1; break; end
        end
    endtask

    task automatic check_writes(input string tag);
        check({tag, ".nwr"}, q_wr.size(), q_exp.size());
        foreach (q_exp[i]) begin
            if (i < q_wr.size()) begin
                check($sformatf("%s.addr%0d", tag, i), q_wr[i][63:32], 32'(4 * i));
                check($sformatf("%s.data%0d", tag, i), q_wr[i][31:0], q_exp[i]);
            end
        end
        q_wr.delete();
    endtask

    // Counts consecutive sampled cycles with the observed signal low, bounded.
    task automatic count_low(input bit use_halt, output int unsigned n);
        n = 0;
        while (((use_halt ? halt : pipe_rst_n) == 1'b0) && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        int unsigned n;
        logic [31:0] w[4];
        bit          exp_loaded;
        bit          exp_error;
        int unsigned exp_writes;
    } prog_vec_t;

    prog_vec_t tbl[5];

    initial begin
        int unsigned n;
        bit el, ee;
        string tag;

        tbl[0] = '{1, '{32'hFC00_0000, 32'h0, 32'h0, 32'h0}, 1'b1, 1'b0, 1};
        tbl[1] = '{3, '{32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFFF, 32'h0}, 1'b1, 1'b0, 3};
        tbl[2] = '{4, '{32'h0000_0001, 32'h4C52_534C, 32'h8000_0000, 32'hF800_0000}, 1'b0, 1'b1, 4};
        tbl[3] = '{2, '{32'hF800_0000, 32'hFC12_3456, 32'h0, 32'h0}, 1'b1, 1'b0, 2};
        tbl[4] = '{4, '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'hFFFF_0000}, 1'b1, 1'b0, 4};

        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; pipe_halted = 1'b0;
        idle(2);
        rst_n = 1'b1;
        check_reset_values("reset");

        // Single word, then HALT word.
        send_byte(8'h4C);
        check("L.state", 32'(state), 32'd1);
        send_word(32'h2001_000F, 0);
        check("w1.state", 32'(state), 32'd2);
        check("w1.we", 32'(we), 32'd1);
        check("w1.data", idata, 32'h2001_000F);
        check("w1.addr", iaddr, 32'h0);
        idle(1);
        check("w1.after_state", 32'(state), 32'd1);
        check("w1.after_we", 32'(we), 32'd0);
        check("w1.after_addr", iaddr, 32'h4);
        send_word(32'hFC00_0000, 0);
        idle(1);
        check("w2.state", 32'(state), 32'd0);
        check("w2.loaded", 32'(loaded), 32'd1);
        check("w2.addr", iaddr, 32'h8);
        q_exp = '{32'h2001_000F, 32'hFC00_0000};
        check_writes("two_words");

        // Run, halt, rerun from DONE.
        send_byte(8'h52);
        check("R.state", 32'(state), 32'd3);
        count_low(1'b0, n);
        check("R.rst_low_cycles", n, 32'd2);
        check("R.run_state", 32'(state), 32'd4);
        check("R.run_halt", 32'(halt), 32'd0);
        send_byte(8'h4C);
        check("run.ignore_L", 32'(state), 32'd4);
        pipe_halted = 1'b1;
        check("run.halt_before", 32'(halt), 32'd0);
        @(negedge clk);
        pipe_halted = 1'b0;
        check("done.halt", 32'(halt), 32'd1);
        check("done.state", 32'(state), 32'd5);
        check("done.rst_n", 32'(pipe_rst_n), 32'd1);
        send_byte(8'h52);
        count_low(1'b0, n);
        check("rerun.rst_low_cycles", n, 32'd2);
        check("rerun.state", 32'(state), 32'd4);
        pipe_halted = 1'b1;
        @(negedge clk);
        pipe_halted = 1'b0;
        check("rerun.done", 32'(state), 32'd5);

`ifdef LOADER_STEP_EN
        send_byte(8'h53);
        check("stepD.state", 32'(state), 32'd6);
        check("stepD.rst_n", 32'(pipe_rst_n), 32'd1);
        count_low(1'b1, n);
        check("stepD.halt_low", n, 32'd1);
        check("stepD.done", 32'(state), 32'd5);
        send_byte(8'h4C);
        send_word(32'hFC00_0000, 0);
        idle(2);
        q_wr.delete();
        send_byte(8'h53);
        check("stepI.state", 32'(state), 32'd3);
        count_low(1'b0, n);
        check("stepI.rst_low", n, 32'd2);
        check("stepI.step_state", 32'(state), 32'd6);
        count_low(1'b1, n);
        check("stepI.halt_low", n, 32'd1);
        check("stepI.done", 32'(state), 32'd5);
        send_byte(8'h53);
        check("step2.rst_n", 32'(pipe_rst_n), 32'd1);
        count_low(1'b1, n);
        check("step2.halt_low", n, 32'd1);
        check("step2.done", 32'(state), 32'd5);
`else
        send_byte(8'h53);
        check("S_ignored.state", 32'(state), 32'd5);
        check("S_ignored.halt", 32'(halt), 32'd1);
`endif

        // Table of complete programs, bytes back to back.
        for (int unsigned t = 0; t < 5; t++) begin
            tag = $sformatf("tbl%0d", t);
            send_byte(8'h4C);
            for (int unsigned i = 0; i < tbl[t].n; i++) send_word(tbl[t].w[i], 0);
            idle(2);
            check({tag, ".state"}, 32'(state), 32'd0);
            check({tag, ".loaded"}, 32'(loaded), 32'(tbl[t].exp_loaded));
            check({tag, ".error"}, 32'(error), 32'(tbl[t].exp_error));
            check({tag, ".addr"}, iaddr, 32'(4 * tbl[t].exp_writes));
            q_exp.delete();
            for (int unsigned i = 0; i < tbl[t].exp_writes; i++) q_exp.push_back(tbl[t].w[i]);
            check_writes(tag);
            if (tbl[t].exp_error) begin
                send_byte(8'h52);
                check({tag, ".R_ignored"}, 32'(state), 32'd0);
                send_byte(8'h4C);
                check({tag, ".L_clears_err"}, 32'(error), 32'd0);
                pulse_reset();
            end
        end

        // Reset mid-word discards partial bytes.
        send_byte(8'h4C);
        send_byte(8'hAA);
        send_byte(8'hBB);
        pulse_reset();
        check_reset_values("midrst");
        send_byte(8'h4C);
        send_word(32'h1234_5678, 0);
        idle(1);
        q_exp = '{32'h1234_5678};
        check_writes("midrst_reload");
        pulse_reset();
        q_wr.delete();

        // Randomized programs with random byte gaps.
        for (int unsigned it = 0; it < 30; it++) begin
            logic [31:0] w;
            tag = $sformatf("rnd%0d", it);
            prog.delete();
            for (int unsigned i = 0; i < $urandom_range(6, 1); i++) begin
                w = $urandom;
                if ($urandom_range(3, 0) == 0) w[31:26] = 6'h3F;
                else if (w[31:26] == 6'h3F) w[26] = 1'b0;
                if ($urandom_range(3, 0) == 0) w[15:8] = 8'h52;
                prog.push_back(w);
            end
            model_load(el, ee);
            send_byte(8'h4C);
            foreach (q_exp[i]) send_word(q_exp[i], 2);
            idle(3);
            check({tag, ".state"}, 32'(state), (el || ee) ? 32'd0 : 32'd1);
            check({tag, ".loaded"}, 32'(loaded), 32'(el));
            check({tag, ".error"}, 32'(error), 32'(ee));
            check_writes(tag);
            if (!el && !ee) begin
                pulse_reset();
            end else if (el && $urandom_range(1, 0) == 1) begin
                send_byte(8'h52);
                n = 0;
                while (state != 3'd4 && n < 10) begin n++; @(negedge clk); end
                check({tag, ".run"}, 32'(state), 32'd4);
                idle($urandom_range(5, 0));
                check({tag, ".run_halt"}, 32'(halt), 32'd0);
                pipe_halted = 1'b1;
                @(negedge clk);
                pipe_halted = 1'b0;
                check({tag, ".done"}, 32'(state), 32'd5);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
